// File: rtl/bus_alu_if.sv
// Control handshake between the bus controller and bus_alu.
// alu_carry exists only when ALU_CARRY_EN is defined.
interface bus_alu_if #(
  parameter int OP_W = 8
);
  logic [OP_W-1:0] opcode;
  logic            alu_valid;
  logic            alu_zero;
`ifdef ALU_CARRY_EN
  logic            alu_carry;

  modport master (output opcode, output alu_valid, input alu_zero, input alu_carry);
  modport slave  (input opcode, input alu_valid, output alu_zero, output alu_carry);
`else
  modport master (output opcode, output alu_valid, input alu_zero);
  modport slave  (input opcode, input alu_valid, output alu_zero);
`endif
endinterface

// File: rtl/bus_alu.sv
// 16-bit accumulator ALU on the shared tri-state data bus; STORE drives the accumulator out.
// Define ALU_CARRY_EN to add the alu_carry flag and the ADC/SBB opcodes.
module bus_alu #(
  parameter int OP_W   = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = OP_W + ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  bus_alu_if.slave          ctrl,
  inout  wire  [DATA_W-1:0] alu_bus
);

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = OP_W'(8'h00),
    OP_LOAD  = OP_W'(8'h01),
    OP_ADD   = OP_W'(8'h02),
    OP_SUB   = OP_W'(8'h03),
    OP_AND   = OP_W'(8'h04),
    OP_OR    = OP_W'(8'h05),
    OP_XOR   = OP_W'(8'h06),
    OP_NOT   = OP_W'(8'h07),
    OP_SHL   = OP_W'(8'h08),
    OP_SHR   = OP_W'(8'h09),
    OP_INC   = OP_W'(8'h0A),
    OP_DEC   = OP_W'(8'h0B),
    OP_CLR   = OP_W'(8'h0C),
    OP_STORE = OP_W'(8'h0D),
    OP_ADC   = OP_W'(8'h0E),
    OP_SBB   = OP_W'(8'h0F)
  } op_e;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zero_q;
  logic              storeEn;

  // The bus is only ever driven for STORE, and never while reset is held.
  assign storeEn      = nrst && ctrl.alu_valid && (ctrl.opcode == OP_STORE);
  assign alu_bus      = storeEn ? acc_q : {DATA_W{1'bz}};
  assign ctrl.alu_zero = zero_q;

`ifdef ALU_CARRY_EN
  logic            carry_q, carry_d;
  logic [DATA_W:0] ext;

  assign ctrl.alu_carry = carry_q;

  // The extra top bit of ext carries out of ADD/ADC or flags a borrow for SUB/SBB/DEC.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    ext     = '0;
    case (ctrl.opcode)
      OP_LOAD: acc_d = alu_bus;
      OP_ADD:  begin ext = {1'b0, acc_q} + {1'b0, alu_bus}; {carry_d, acc_d} = ext; end
      OP_SUB:  begin ext = {1'b0, acc_q} - {1'b0, alu_bus}; {carry_d, acc_d} = ext; end
      OP_ADC:  begin
        ext = {1'b0, acc_q} + {1'b0, alu_bus} + (DATA_W+1)'(carry_q);
        {carry_d, acc_d} = ext;
      end
      OP_SBB:  begin
        ext = {1'b0, acc_q} - {1'b0, alu_bus} - (DATA_W+1)'(carry_q);
        {carry_d, acc_d} = ext;
      end
      OP_AND:  acc_d = acc_q & alu_bus;
      OP_OR:   acc_d = acc_q | alu_bus;
      OP_XOR:  acc_d = acc_q ^ alu_bus;
      OP_NOT:  acc_d = ~acc_q;
      OP_SHL:  begin acc_d = {acc_q[DATA_W-2:0], 1'b0}; carry_d = acc_q[DATA_W-1]; end
      OP_SHR:  begin acc_d = {1'b0, acc_q[DATA_W-1:1]}; carry_d = acc_q[0]; end
      OP_INC:  begin ext = {1'b0, acc_q} + (DATA_W+1)'(1); {carry_d, acc_d} = ext; end
      OP_DEC:  begin ext = {1'b0, acc_q} - (DATA_W+1)'(1); {carry_d, acc_d} = ext; end
      OP_CLR:  acc_d = '0;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
    end else if (ctrl.alu_valid) begin
      acc_q   <= acc_d;
      zero_q  <= (acc_d == '0);
      carry_q <= carry_d;
    end
  end
`else
  always_comb begin
    acc_d = acc_q;
    case (ctrl.opcode)
      OP_LOAD: acc_d = alu_bus;
      OP_ADD:  acc_d = acc_q + alu_bus;
      OP_SUB:  acc_d = acc_q - alu_bus;
      OP_AND:  acc_d = acc_q & alu_bus;
      OP_OR:   acc_d = acc_q | alu_bus;
      OP_XOR:  acc_d = acc_q ^ alu_bus;
      OP_NOT:  acc_d = ~acc_q;
      OP_SHL:  acc_d = {acc_q[DATA_W-2:0], 1'b0};
      OP_SHR:  acc_d = {1'b0, acc_q[DATA_W-1:1]};
      OP_INC:  acc_d = acc_q + DATA_W'(1);
      OP_DEC:  acc_d = acc_q - DATA_W'(1);
      OP_CLR:  acc_d = '0;
      default: acc_d = acc_q;
    endcase
  end

  // Any executed code, even a NOP-class one, refreshes the zero flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q  <= '0;
      zero_q <= 1'b1;
    end else if (ctrl.alu_valid) begin
      acc_q  <= acc_d;
      zero_q <= (acc_d == '0);
    end
  end
`endif

endmodule

// File: tb/tb_bus_alu.sv
// Self-checking bench for bus_alu: directed scenarios plus a randomized run against an integer model.
// The accumulator is observed by issuing STORE and reading the bus; a pulldown makes a released bus read 0.
module tb_bus_alu;

  logic        clk;
  logic        nrst;
  logic [15:0] busDrv;
  logic        busOe;
  wire  [15:0] aluBus;

  int checks   = 0;
  int failures = 0;

  logic [15:0] modelAcc;
  logic        modelZero;
  logic        modelCarry;

  bus_alu_if #(.OP_W(8)) aluIf ();

  assign aluBus = busOe ? busDrv : 16'hzzzz;
  pulldown (aluBus);

  bus_alu dut (
    .clk     (clk),
    .nrst    (nrst),
    .ctrl    (aluIf),
    .alu_bus (aluBus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    modelAcc   = 16'h0000;
    modelZero  = 1'b1;
    modelCarry = 1'b0;
  endfunction

  // Arithmetic on plain integers, wrapped to 16 bits at the end.
  function automatic void modelStep(input logic [7:0] op, input logic [15:0] b);
    int a, bv, r, c;
    a  = int'(modelAcc);
    bv = int'(b);
    c  = int'(modelCarry);
    r  = a;
    case (op)
      8'h01: r = bv;
      8'h02: begin r = a + bv; c = int'(r > 65535); end
      8'h03: begin r = a - bv; c = int'(r < 0); end
      8'h04: r = a & bv;
      8'h05: r = a | bv;
      8'h06: r = a ^ bv;
      8'h07: r = 65535 - a;
      8'h08: begin r = a * 2; c = a / 32768; end
      8'h09: begin r = a / 2; c = a % 2; end
      8'h0A: begin r = a + 1; c = int'(r > 65535); end
      8'h0B: begin r = a - 1; c = int'(r < 0); end
      8'h0C: r = 0;
`ifdef ALU_CARRY_EN
      8'h0E: begin r = a + bv + c; c = int'(r > 65535); end
      8'h0F: begin r = a - bv - c; c = int'(r < 0); end
`endif
      default: r = a;
    endcase
    modelAcc   = 16'(r & 65535);
    modelZero  = (modelAcc == 16'h0000);
    modelCarry = c[0];
  endfunction

  // Presents one op for exactly one rising edge, starting and ending at a falling edge.
  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] b);
    aluIf.opcode    = op;
    aluIf.alu_valid = 1'b1;
    busOe           = (op != 8'h0D);
    busDrv          = b;
    @(negedge clk);
    modelStep(op, b);
    aluIf.alu_valid = 1'b0;
    busOe           = 1'b0;
  endtask

  // STORE drives the bus combinationally, so this samples without consuming a clock edge.
  task automatic readAcc(output logic [15:0] v);
    aluIf.opcode    = 8'h0D;
    aluIf.alu_valid = 1'b1;
    busOe           = 1'b0;
    #1 v = aluBus;
    aluIf.alu_valid = 1'b0;
    aluIf.opcode    = 8'h00;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    nrst            = 1'b1;
    aluIf.opcode    = 8'h00;
    aluIf.alu_valid = 1'b0;
    busOe           = 1'b0;
    busDrv          = 16'h0000;
    #5 nrst = 1'b0;
    #1;
    checks++;
    if (aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_zero: alu_zero=%0b expected 1", aluIf.alu_zero);
    end
    checks++;
    if (aluBus !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_bus_released: bus=%h expected released (0000)", aluBus);
    end
    #9;
    nrst            = 1'b1;
    aluIf.alu_valid = 1'b1;
    aluIf.opcode    = 8'h00;
    modelReset();
    @(posedge clk);
    #1;
    aluIf.alu_valid = 1'b0;
    checks++;
    if (aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_nop_zero: alu_zero=%0b expected 1", aluIf.alu_zero);
    end
`ifdef ALU_CARRY_EN
    checks++;
    if (aluIf.alu_carry !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_carry: alu_carry=%0b expected 0", aluIf.alu_carry);
    end
`endif
    readAcc(v);
    checks++;
    if (v !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_acc: acc=%h expected 0000", v);
    end
    @(negedge clk);
  endtask

  task automatic test_load_zero();
    logic [15:0] v;
    applyStimulus(8'h01, 16'h0012);
    checks++;
    if (aluIf.alu_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_zero: alu_zero=%0b expected 0", aluIf.alu_zero);
    end
    applyStimulus(8'h03, 16'h0012);
    checks++;
    if (aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sub_to_zero: alu_zero=%0b expected 1", aluIf.alu_zero);
    end
    readAcc(v);
    checks++;
    if (v !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL sub_to_zero_acc: acc=%h expected 0000", v);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    applyStimulus(8'h01, 16'hFFFF);
    applyStimulus(8'h0A, 16'h0000);
    readAcc(v);
    checks++;
    if (v !== 16'h0000 || aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL inc_wrap: acc=%h zero=%0b expected 0000 zero=1", v, aluIf.alu_zero);
    end
`ifdef ALU_CARRY_EN
    checks++;
    if (aluIf.alu_carry !== 1'b1) begin
      failures++;
      $display("[TB] FAIL inc_wrap_carry: alu_carry=%0b expected 1", aluIf.alu_carry);
    end
`endif
    applyStimulus(8'h0B, 16'h0000);
    readAcc(v);
    checks++;
    if (v !== 16'hFFFF || aluIf.alu_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dec_wrap: acc=%h zero=%0b expected ffff zero=0", v, aluIf.alu_zero);
    end
`ifdef ALU_CARRY_EN
    checks++;
    if (aluIf.alu_carry !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dec_wrap_borrow: alu_carry=%0b expected 1", aluIf.alu_carry);
    end
`endif
    applyStimulus(8'h02, 16'h0001);
    readAcc(v);
    checks++;
    if (v !== 16'h0000 || aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL add_wrap: acc=%h zero=%0b expected 0000 zero=1", v, aluIf.alu_zero);
    end
  endtask

  task automatic test_logic_shift();
    logic [15:0] v;
    logic [7:0]  ops [4]  = '{8'h05, 8'h08, 8'h09, 8'h06};
    logic [15:0] opnd [4] = '{16'h0F00, 16'h0000, 16'h0000, 16'h0FF0};
    logic [15:0] want [4] = '{16'h0FF0, 16'h1FE0, 16'h0FF0, 16'h0000};
    applyStimulus(8'h01, 16'h00F0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], opnd[i]);
      readAcc(v);
      checks++;
      if (v !== want[i] || aluIf.alu_zero !== (want[i] == 16'h0000)) begin
        failures++;
        $display("[TB] FAIL logic_shift op=%h: acc=%h zero=%0b expected %h zero=%0b",
                 ops[i], v, aluIf.alu_zero, want[i], (want[i] == 16'h0000));
      end
    end
  endtask

  task automatic test_store();
    logic [15:0] v;
    applyStimulus(8'h01, 16'h1234);
    readAcc(v);
    checks++;
    if (v !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL store_drive: bus=%h expected 1234", v);
    end
    #1;
    checks++;
    if (aluBus !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL store_release: bus=%h expected released (0000)", aluBus);
    end
    applyStimulus(8'h0D, 16'h0000);
    readAcc(v);
    checks++;
    if (v !== 16'h1234 || aluIf.alu_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL store_keeps_acc: acc=%h zero=%0b expected 1234 zero=0", v, aluIf.alu_zero);
    end
  endtask

  task automatic test_hold_illegal();
    logic [15:0] v;
    applyStimulus(8'h01, 16'h0055);
    aluIf.opcode    = 8'h02;
    aluIf.alu_valid = 1'b0;
    busOe           = 1'b1;
    busDrv          = 16'h0005;
    repeat (5) @(negedge clk);
    busOe = 1'b0;
    readAcc(v);
    checks++;
    if (v !== 16'h0055 || aluIf.alu_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_no_valid: acc=%h zero=%0b expected 0055 zero=0", v, aluIf.alu_zero);
    end
    applyStimulus(8'h7F, 16'h1111);
    readAcc(v);
    checks++;
    if (v !== 16'h0055) begin
      failures++;
      $display("[TB] FAIL illegal_7f: acc=%h expected 0055", v);
    end
    applyStimulus(8'h0E, 16'h1111);
    applyStimulus(8'h0F, 16'h0101);
    readAcc(v);
    checks++;
    if (v !== modelAcc || aluIf.alu_zero !== modelZero) begin
      failures++;
      $display("[TB] FAIL codes_0e_0f: acc=%h zero=%0b expected %h zero=%0b",
               v, aluIf.alu_zero, modelAcc, modelZero);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [7:0]  op;
    logic [15:0] b;
    for (int i = 0; i < 150; i++) begin
      op = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(16, 255));
      b = 16'($urandom);
      if ($urandom_range(0, 4) == 0) b = modelAcc;
      applyStimulus(op, b);
      readAcc(v);
      checks++;
      if (v !== modelAcc || aluIf.alu_zero !== modelZero) begin
        failures++;
        $display("[TB] FAIL random step %0d op=%h b=%h: acc=%h zero=%0b expected %h zero=%0b",
                 i, op, b, v, aluIf.alu_zero, modelAcc, modelZero);
      end
`ifdef ALU_CARRY_EN
      checks++;
      if (aluIf.alu_carry !== modelCarry) begin
        failures++;
        $display("[TB] FAIL random_carry step %0d op=%h: alu_carry=%0b expected %0b",
                 i, op, aluIf.alu_carry, modelCarry);
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    applyStimulus(8'h01, 16'hBEEF);
    aluIf.opcode    = 8'h02;
    aluIf.alu_valid = 1'b1;
    busOe           = 1'b1;
    busDrv          = 16'h0001;
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_zero: alu_zero=%0b expected 1", aluIf.alu_zero);
    end
    @(negedge clk);
    nrst            = 1'b1;
    aluIf.alu_valid = 1'b0;
    busOe           = 1'b0;
    modelReset();
    readAcc(v);
    checks++;
    if (v !== 16'h0000 || aluIf.alu_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_acc: acc=%h zero=%0b expected 0000 zero=1", v, aluIf.alu_zero);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_load_zero();
    test_wrap();
    test_logic_shift();
    test_store();
    test_hold_illegal();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
